// File: rtl/cpu_cfg_table.sv
// CPU-programmable forwarding/VPI translation table with Intel/Motorola slave port
// and a fully pipelined lookup port. Define CFG_TABLE_PARITY_EN for per-entry parity.
module cpu_cfg_table #(
  parameter int unsigned NUM_TX      = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busmode,
  input  logic [ADDR_W-1:0] addr,
  input  logic              sel,
  input  logic [NUM_TX-1:0] datain_fwd,
  input  logic [11:0]       datain_vpi,
  output logic [NUM_TX-1:0] dataout_fwd,
  output logic [11:0]       dataout_vpi,
  input  logic              rd_DS,
  input  logic              wr_RW,
  output logic              rdy_Dtack,
`ifdef CFG_TABLE_PARITY_EN
  output logic              lk_perr,
`endif
  input  logic              lk_req,
  input  logic [ADDR_W-1:0] lk_idx,
  output logic              lk_valid,
  output logic [NUM_TX-1:0] lk_fwd,
  output logic [11:0]       lk_vpi
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned EntW  = NUM_TX + 12;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  localparam logic [3:0] WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [1:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_TX-1:0] wfwd_q, wfwd_d;
  logic [11:0]       wvpi_q, wvpi_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [EntW-1:0]   mem_q [Depth];
  logic [EntW-1:0]   mem_d [Depth];
  logic [NUM_TX-1:0] dout_fwd_q, dout_fwd_d;
  logic [11:0]       dout_vpi_q, dout_vpi_d;
  logic              lk_valid_q, lk_valid_d;
  logic [NUM_TX-1:0] lk_fwd_q, lk_fwd_d;
  logic [11:0]       lk_vpi_q, lk_vpi_d;
  logic [EntW-1:0]   lk_ent;
  logic [EntW-1:0]   rd_ent;
`ifdef CFG_TABLE_PARITY_EN
  logic              par_q [Depth];
  logic              par_d [Depth];
  logic              lk_perr_q, lk_perr_d;
`endif

  logic start, start_wr, strobe_act, live;

  // Intel needs exactly one strobe low; Motorola uses ds_n with rw as direction.
  assign start      = busmode ? (!sel && (rd_DS ^ wr_RW)) : (!sel && !rd_DS);
  assign start_wr   = !wr_RW;
  assign strobe_act = mode_q ? (wr_q ? !wr_RW : !rd_DS) : !rd_DS;
  assign live       = !sel && strobe_act;

  assign lk_ent = mem_q[lk_idx];
  assign rd_ent = mem_q[addr_q];

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wfwd_d     = wfwd_q;
    wvpi_d     = wvpi_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    dout_fwd_d = dout_fwd_q;
    dout_vpi_d = dout_vpi_q;
`ifdef CFG_TABLE_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = busmode;
          wr_d    = start_wr;
          addr_d  = addr;
          wfwd_d  = datain_fwd;
          wvpi_d  = datain_vpi;
          cnt_d   = WaitInit;
          state_d = (WAIT_STATES == 0) ? StAck : StWait;
        end
      end
      StWait: begin
        if (!live) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        state_d = StHold;
        if (wr_q) begin
          mem_d[addr_q] = {wfwd_q, wvpi_q};
`ifdef CFG_TABLE_PARITY_EN
          par_d[addr_q] = ^{wfwd_q, wvpi_q};
`endif
        end else begin
          dout_fwd_d = rd_ent[EntW-1:12];
          dout_vpi_d = rd_ent[11:0];
        end
      end
      StHold: begin
        if (!live) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Lookup reads the registered table, so a same-cycle CPU write is not visible yet.
  always_comb begin
    lk_valid_d = lk_req;
    lk_fwd_d   = lk_req ? lk_ent[EntW-1:12] : '0;
    lk_vpi_d   = lk_req ? lk_ent[11:0] : '0;
`ifdef CFG_TABLE_PARITY_EN
    lk_perr_d  = lk_req && (^{lk_ent, par_q[lk_idx]});
`endif
  end

  always_comb begin
    case (state_q)
      StAck, StHold: rdy_Dtack = mode_q;
      StWait:        rdy_Dtack = !mode_q;
      default:       rdy_Dtack = !busmode;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wfwd_q     <= '0;
      wvpi_q     <= '0;
      cnt_q      <= '0;
      mem_q      <= '{default: '0};
      dout_fwd_q <= '0;
      dout_vpi_q <= '0;
      lk_valid_q <= 1'b0;
      lk_fwd_q   <= '0;
      lk_vpi_q   <= '0;
`ifdef CFG_TABLE_PARITY_EN
      par_q      <= '{default: 1'b0};
      lk_perr_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wfwd_q     <= wfwd_d;
      wvpi_q     <= wvpi_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      dout_fwd_q <= dout_fwd_d;
      dout_vpi_q <= dout_vpi_d;
      lk_valid_q <= lk_valid_d;
      lk_fwd_q   <= lk_fwd_d;
      lk_vpi_q   <= lk_vpi_d;
`ifdef CFG_TABLE_PARITY_EN
      par_q      <= par_d;
      lk_perr_q  <= lk_perr_d;
`endif
    end
  end

  assign dataout_fwd = dout_fwd_q;
  assign dataout_vpi = dout_vpi_q;
  assign lk_valid    = lk_valid_q;
  assign lk_fwd      = lk_fwd_q;
  assign lk_vpi      = lk_vpi_q;
`ifdef CFG_TABLE_PARITY_EN
  assign lk_perr     = lk_perr_q;
`endif

endmodule

// File: tb/tb_cpu_cfg_table.sv
// Directed bench for cpu_cfg_table: one instance with WAIT_STATES=1, one with 3, shared inputs.
module tb_cpu_cfg_table;

  logic        clk = 1'b0;
  logic        rst, busmode, sel, rd_DS, wr_RW, lk_req;
  logic [7:0]  addr, lk_idx;
  logic [3:0]  datain_fwd;
  logic [11:0] datain_vpi;

  logic [3:0]  dataout_fwd, lk_fwd, dataout_fwd3, lk_fwd3;
  logic [11:0] dataout_vpi, lk_vpi, dataout_vpi3, lk_vpi3;
  logic        rdy, lk_valid, rdy3, lk_valid3;
`ifdef CFG_TABLE_PARITY_EN
  logic        lk_perr, lk_perr3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_cfg_table #(.NUM_TX(4), .ADDR_W(8), .WAIT_STATES(1)) u_dut (
    .clk(clk), .rst(rst), .busmode(busmode), .addr(addr), .sel(sel),
    .datain_fwd(datain_fwd), .datain_vpi(datain_vpi),
    .dataout_fwd(dataout_fwd), .dataout_vpi(dataout_vpi),
    .rd_DS(rd_DS), .wr_RW(wr_RW), .rdy_Dtack(rdy),
`ifdef CFG_TABLE_PARITY_EN
    .lk_perr(lk_perr),
`endif
    .lk_req(lk_req), .lk_idx(lk_idx), .lk_valid(lk_valid), .lk_fwd(lk_fwd), .lk_vpi(lk_vpi)
  );

  cpu_cfg_table #(.NUM_TX(4), .ADDR_W(8), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .busmode(busmode), .addr(addr), .sel(sel),
    .datain_fwd(datain_fwd), .datain_vpi(datain_vpi),
    .dataout_fwd(dataout_fwd3), .dataout_vpi(dataout_vpi3),
    .rd_DS(rd_DS), .wr_RW(wr_RW), .rdy_Dtack(rdy3),
`ifdef CFG_TABLE_PARITY_EN
    .lk_perr(lk_perr3),
`endif
    .lk_req(lk_req), .lk_idx(lk_idx), .lk_valid(lk_valid3), .lk_fwd(lk_fwd3), .lk_vpi(lk_vpi3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_bus();
    sel   = 1'b1;
    rd_DS = 1'b1;
    wr_RW = 1'b1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [3:0] f, input logic [11:0] v);
    busmode = 1'b1; addr = a; datain_fwd = f; datain_vpi = v;
    sel = 1'b0; wr_RW = 1'b0; rd_DS = 1'b1;
    step(); step(); step();
    release_bus();
    step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b1; busmode = 1'b1; lk_req = 1'b0; lk_idx = '0; addr = '0;
    datain_fwd = '0; datain_vpi = '0;
    release_bus();
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy_intel got %b exp 0", rdy); end
    checks++; if (dataout_fwd !== 4'h0 || dataout_vpi !== 12'h0) begin
      errors++; $display("FAIL reset_dataout got %h/%h exp 0/0", dataout_fwd, dataout_vpi);
    end
    checks++; if (lk_valid !== 1'b0 || lk_fwd !== 4'h0 || lk_vpi !== 12'h0) begin
      errors++; $display("FAIL reset_lookup got %b %h/%h exp 0 0/0", lk_valid, lk_fwd, lk_vpi);
    end
    busmode = 1'b0; #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy_moto got %b exp 1", rdy); end
    busmode = 1'b1; #1;
  endtask

  task automatic test_intel_write();
    busmode = 1'b1; addr = 8'h05; datain_fwd = 4'b1010; datain_vpi = 12'h123;
    sel = 1'b0; wr_RW = 1'b0; rd_DS = 1'b1;
    step();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL iwr_wait_rdy got %b exp 0", rdy); end
    step();
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL iwr_ack_rdy got %b exp 1", rdy); end
    step();
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL iwr_hold_rdy got %b exp 1", rdy); end
    release_bus();
    lk_req = 1'b1; lk_idx = 8'h05;
    step();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL iwr_idle_rdy got %b exp 0", rdy); end
    checks++; if (lk_valid !== 1'b1 || lk_fwd !== 4'b1010 || lk_vpi !== 12'h123) begin
      errors++; $display("FAIL iwr_lookup got %b %h/%h exp 1 a/123", lk_valid, lk_fwd, lk_vpi);
    end
`ifdef CFG_TABLE_PARITY_EN
    checks++; if (lk_perr !== 1'b0) begin errors++; $display("FAIL iwr_perr got %b exp 0", lk_perr); end
`endif
    lk_req = 1'b0;
    step();
    checks++; if (lk_valid !== 1'b0) begin errors++; $display("FAIL iwr_valid_drop got %b exp 0", lk_valid); end
  endtask

  task automatic test_moto_read();
    busmode = 1'b0; addr = 8'h05; sel = 1'b0; rd_DS = 1'b0; wr_RW = 1'b1;
    step();
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL mrd_wait_dtack got %b exp 1", rdy); end
    step();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mrd_ack_dtack got %b exp 0", rdy); end
    busmode = 1'b1; #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mrd_busmode_flip got %b exp 0", rdy); end
    busmode = 1'b0;
    step();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mrd_hold_dtack got %b exp 0", rdy); end
    checks++; if (dataout_fwd !== 4'b1010 || dataout_vpi !== 12'h123) begin
      errors++; $display("FAIL mrd_data got %h/%h exp a/123", dataout_fwd, dataout_vpi);
    end
    release_bus();
    step();
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL mrd_release got %b exp 1", rdy); end
    step();
    checks++; if (dataout_fwd !== 4'b1010 || dataout_vpi !== 12'h123) begin
      errors++; $display("FAIL mrd_data_hold got %h/%h exp a/123", dataout_fwd, dataout_vpi);
    end
    busmode = 1'b1;
    step();
  endtask

  task automatic test_intel_ignore();
    busmode = 1'b1; addr = 8'h05; datain_fwd = 4'b0101; datain_vpi = 12'hFED;
    sel = 1'b0; rd_DS = 1'b0; wr_RW = 1'b0;
    step(); step(); step();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL ign_rdy got %b exp 0", rdy); end
    release_bus();
    lk_req = 1'b1; lk_idx = 8'h05;
    step();
    checks++; if (lk_fwd !== 4'b1010 || lk_vpi !== 12'h123) begin
      errors++; $display("FAIL ign_entry got %h/%h exp a/123", lk_fwd, lk_vpi);
    end
    lk_req = 1'b0;
    step();
  endtask

  task automatic test_abort_wait();
    busmode = 1'b1; addr = 8'h20; datain_fwd = 4'b1001; datain_vpi = 12'h456;
    sel = 1'b0; wr_RW = 1'b0; rd_DS = 1'b1;
    step();
    checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL abort_wait1 got %b exp 0", rdy3); end
    step();
    checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL abort_wait2 got %b exp 0", rdy3); end
    release_bus();
    step(); step();
    checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL abort_after got %b exp 0", rdy3); end
    busmode = 1'b0; #1;
    checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL abort_idle got %b exp 1", rdy3); end
    busmode = 1'b1;
    lk_req = 1'b1; lk_idx = 8'h20;
    step();
    checks++; if (lk_valid3 !== 1'b1 || lk_fwd3 !== 4'h0 || lk_vpi3 !== 12'h0) begin
      errors++; $display("FAIL abort_entry got %b %h/%h exp 1 0/0", lk_valid3, lk_fwd3, lk_vpi3);
    end
    lk_req = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_same_cycle();
    cpu_write(8'h10, 4'b0011, 12'h0AB);
    addr = 8'h10; datain_fwd = 4'b0100; datain_vpi = 12'h007;
    sel = 1'b0; wr_RW = 1'b0; rd_DS = 1'b1;
    step(); step();
    lk_req = 1'b1; lk_idx = 8'h10;
    step();
    checks++; if (lk_valid !== 1'b1 || lk_fwd !== 4'b0011 || lk_vpi !== 12'h0AB) begin
      errors++; $display("FAIL same_old got %b %h/%h exp 1 3/0ab", lk_valid, lk_fwd, lk_vpi);
    end
    release_bus();
    step();
    checks++; if (lk_fwd !== 4'b0100 || lk_vpi !== 12'h007) begin
      errors++; $display("FAIL same_new got %h/%h exp 4/007", lk_fwd, lk_vpi);
    end
    lk_req = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_reset_in_ack();
    busmode = 1'b1; addr = 8'h33; datain_fwd = 4'b1111; datain_vpi = 12'hFFF;
    sel = 1'b0; wr_RW = 1'b0; rd_DS = 1'b1;
    step(); step();
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rack_ack got %b exp 1", rdy); end
    rst = 1'b1;
    release_bus();
    step();
    rst = 1'b0;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rack_rdy got %b exp 0", rdy); end
    lk_req = 1'b1; lk_idx = 8'h33;
    step();
    checks++; if (lk_fwd !== 4'h0 || lk_vpi !== 12'h0) begin
      errors++; $display("FAIL rack_entry got %h/%h exp 0/0", lk_fwd, lk_vpi);
    end
    lk_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    lk_req = 1'b1;
    for (int i = 0; i < 256; i++) begin
      lk_idx = 8'(i);
      step();
      checks++;
      if (lk_valid !== 1'b1 || lk_fwd !== 4'h0 || lk_vpi !== 12'h0
`ifdef CFG_TABLE_PARITY_EN
          || lk_perr !== 1'b0
`endif
          ) begin
        errors++;
        if (bad < 5) $display("FAIL b2b_idx%0d got %b %h/%h exp 1 0/0", i, lk_valid, lk_fwd, lk_vpi);
        bad++;
      end
    end
    lk_req = 1'b0;
    step();
    checks++; if (lk_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", lk_valid); end
  endtask

  initial begin
    test_reset();
    test_intel_write();
    test_moto_read();
    test_intel_ignore();
    test_abort_wait();
    test_same_cycle();
    test_reset_in_ack();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
